// File: rtl/sc_game_pkg.sv
// sc_game_pkg: state encoding and width helpers shared by the game-flow controllers.
package sc_game_pkg;
  typedef enum logic [2:0] {
    RESET = 3'd0,
    START = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    PLAY  = 3'd4,
    LOSE  = 3'd5,
    WIN   = 3'd6
  } state_t;
  localparam int TIMEOUT_MIN_W = 26;
  function automatic int countWidth(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction
  function automatic int timeoutWidth(input int cycles);
    return ($clog2(cycles) > TIMEOUT_MIN_W) ? $clog2(cycles) : TIMEOUT_MIN_W;
  endfunction
endpackage

// File: rtl/sc_edge_detect_low.sv
// sc_edge_detect_low: one-cycle pulse on the falling edge of an active-low synchronous input.
// Ports: SC_EDGEDETECTLOW_CLOCK_50 clock, SC_EDGEDETECTLOW_RESET_InLow async active-low reset,
//        SC_EDGEDETECTLOW_signal_InLow monitored input, SC_EDGEDETECTLOW_fall_Out pulse (high one cycle).
module sc_edge_detect_low (
  input  logic SC_EDGEDETECTLOW_CLOCK_50,
  input  logic SC_EDGEDETECTLOW_RESET_InLow,
  input  logic SC_EDGEDETECTLOW_signal_InLow,
  output logic SC_EDGEDETECTLOW_fall_Out
);
  logic prevSignal;
  always_ff @(posedge SC_EDGEDETECTLOW_CLOCK_50 or negedge SC_EDGEDETECTLOW_RESET_InLow)
    if (!SC_EDGEDETECTLOW_RESET_InLow) prevSignal <= 1'b1;
    else prevSignal <= SC_EDGEDETECTLOW_signal_InLow;
  assign SC_EDGEDETECTLOW_fall_Out = prevSignal && !SC_EDGEDETECTLOW_signal_InLow;
endmodule

// File: rtl/sc_statemachine_levels.sv
// sc_statemachine_levels: game-flow controller sequencing NUM_LEVELS levels with a lives budget.
// Ports: CLOCK_50 clock, RESET_InLow async active-low reset, startButton_InLow debounced start,
//        lose_inLow/win_inLow datapath events, clear_OutLow/load_OutLow one-cycle strobes,
//        lose_outLow/win_outLow game-over/game-won, nivel level (0 when idle), lives, playing_out.
// Optional: define SC_STATEMACHINELEVELS_TIMEOUT_EN to expire a level after TIMEOUT_CYCLES PLAY cycles.
module sc_statemachine_levels
  import sc_game_pkg::*;
#(
  parameter int NUM_LEVELS     = 4,
  parameter int MAX_LIVES      = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int LEVEL_W        = countWidth(NUM_LEVELS),
  parameter int LIVES_W        = countWidth(MAX_LIVES)
) (
  input  logic               SC_STATEMACHINELEVELS_CLOCK_50,
  input  logic               SC_STATEMACHINELEVELS_RESET_InLow,
  input  logic               SC_STATEMACHINELEVELS_startButton_InLow,
  input  logic               SC_STATEMACHINELEVELS_lose_inLow,
  input  logic               SC_STATEMACHINELEVELS_win_inLow,
  output logic               SC_STATEMACHINELEVELS_clear_OutLow,
  output logic               SC_STATEMACHINELEVELS_load_OutLow,
  output logic               SC_STATEMACHINELEVELS_lose_outLow,
  output logic               SC_STATEMACHINELEVELS_win_outLow,
  output logic [LEVEL_W-1:0] SC_STATEMACHINELEVELS_nivel,
  output logic [LIVES_W-1:0] SC_STATEMACHINELEVELS_lives,
  output logic               SC_STATEMACHINELEVELS_playing_out
);
  state_t state, stateNext;
  logic [LEVEL_W-1:0] level, levelNext;
  logic [LIVES_W-1:0] lives, livesNext;
  logic startEvent;
  logic loseHit;

  sc_edge_detect_low startEdge (
    .SC_EDGEDETECTLOW_CLOCK_50    (SC_STATEMACHINELEVELS_CLOCK_50),
    .SC_EDGEDETECTLOW_RESET_InLow (SC_STATEMACHINELEVELS_RESET_InLow),
    .SC_EDGEDETECTLOW_signal_InLow(SC_STATEMACHINELEVELS_startButton_InLow),
    .SC_EDGEDETECTLOW_fall_Out    (startEvent)
  );

`ifdef SC_STATEMACHINELEVELS_TIMEOUT_EN
  localparam int CNT_W = timeoutWidth(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] timeoutCount;
  always_ff @(posedge SC_STATEMACHINELEVELS_CLOCK_50 or negedge SC_STATEMACHINELEVELS_RESET_InLow)
    if (!SC_STATEMACHINELEVELS_RESET_InLow) timeoutCount <= '0;
    else if (state == LOAD) timeoutCount <= '0;
    else if (state == PLAY) timeoutCount <= timeoutCount + CNT_W'(1);
  // An expired level counts exactly like a lost one.
  assign loseHit = !SC_STATEMACHINELEVELS_lose_inLow || (timeoutCount == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign loseHit = !SC_STATEMACHINELEVELS_lose_inLow;
`endif

  always_ff @(posedge SC_STATEMACHINELEVELS_CLOCK_50 or negedge SC_STATEMACHINELEVELS_RESET_InLow)
    if (!SC_STATEMACHINELEVELS_RESET_InLow) begin
      state <= RESET;
      level <= '0;
      lives <= '0;
    end else begin
      state <= stateNext;
      level <= levelNext;
      lives <= livesNext;
    end

  always_comb begin
    stateNext = state;
    levelNext = level;
    livesNext = lives;
    case (state)
      RESET: stateNext = START;
      START: begin
        levelNext = LEVEL_W'(1);
        livesNext = LIVES_W'(MAX_LIVES);
        stateNext = CHECK;
      end
      CHECK: stateNext = startEvent ? LOAD : CHECK;
      LOAD:  stateNext = PLAY;
      PLAY:
        if (loseHit) begin
          livesNext = lives - LIVES_W'(1);
          stateNext = (lives > LIVES_W'(1)) ? LOAD : LOSE;
        end else if (!SC_STATEMACHINELEVELS_win_inLow) begin
          levelNext = (level < LEVEL_W'(NUM_LEVELS)) ? level + LEVEL_W'(1) : level;
          stateNext = (level < LEVEL_W'(NUM_LEVELS)) ? LOAD : WIN;
        end
      LOSE:    stateNext = startEvent ? START : LOSE;
      WIN:     stateNext = startEvent ? START : WIN;
      default: stateNext = RESET;
    endcase
  end

  assign SC_STATEMACHINELEVELS_clear_OutLow = state != START;
  assign SC_STATEMACHINELEVELS_load_OutLow  = state != LOAD;
  assign SC_STATEMACHINELEVELS_lose_outLow  = state != LOSE;
  assign SC_STATEMACHINELEVELS_win_outLow   = state != WIN;
  assign SC_STATEMACHINELEVELS_playing_out  = state == PLAY;
  assign SC_STATEMACHINELEVELS_nivel = (state == LOAD || state == PLAY) ? level : '0;
  // Only the unused 3'd7 encoding lies above WIN; it shows no lives.
  assign SC_STATEMACHINELEVELS_lives = (state > WIN) ? '0 : lives;
endmodule

// File: tb/tb_sc_statemachine_levels.sv
// tb_sc_statemachine_levels: scoreboard bench for the level/lives game-flow controller.
module tb_sc_statemachine_levels;
  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b1, loseIn = 1'b1, winIn = 1'b1;
  logic clr, ld, lo, wo, pl;
  logic [2:0] niv;
  logic [1:0] liv;
  int vectors = 0, miscompares = 0;
  logic [2:0] stimQ[$];
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  sc_statemachine_levels #(.NUM_LEVELS(4), .MAX_LIVES(3), .TIMEOUT_CYCLES(16)) dut (
    .SC_STATEMACHINELEVELS_CLOCK_50        (clk),
    .SC_STATEMACHINELEVELS_RESET_InLow     (rst_n),
    .SC_STATEMACHINELEVELS_startButton_InLow(btn),
    .SC_STATEMACHINELEVELS_lose_inLow      (loseIn),
    .SC_STATEMACHINELEVELS_win_inLow       (winIn),
    .SC_STATEMACHINELEVELS_clear_OutLow    (clr),
    .SC_STATEMACHINELEVELS_load_OutLow     (ld),
    .SC_STATEMACHINELEVELS_lose_outLow     (lo),
    .SC_STATEMACHINELEVELS_win_outLow      (wo),
    .SC_STATEMACHINELEVELS_nivel           (niv),
    .SC_STATEMACHINELEVELS_lives           (liv),
    .SC_STATEMACHINELEVELS_playing_out     (pl)
  );

  function automatic logic [9:0] obs();
    return {clr, ld, lo, wo, pl, niv, liv};
  endfunction
  function automatic logic [9:0] pk(input logic c, l, ol, ow, p, input logic [2:0] n, input logic [1:0] v);
    return {c, l, ol, ow, p, n, v};
  endfunction
  function automatic logic [9:0] rstv();           return pk(1, 1, 1, 1, 0, 0, 0); endfunction
  function automatic logic [9:0] st(input int v);   return pk(0, 1, 1, 1, 0, 0, 2'(v)); endfunction
  function automatic logic [9:0] idle(input int v); return pk(1, 1, 1, 1, 0, 0, 2'(v)); endfunction
  function automatic logic [9:0] ldv(input int n, v); return pk(1, 0, 1, 1, 0, 3'(n), 2'(v)); endfunction
  function automatic logic [9:0] plv(input int n, v); return pk(1, 1, 1, 1, 1, 3'(n), 2'(v)); endfunction
  function automatic logic [9:0] lov();             return pk(1, 1, 0, 1, 0, 0, 0); endfunction
  function automatic logic [9:0] wov(input int v);  return pk(1, 1, 1, 0, 0, 0, 2'(v)); endfunction

  // stimulus {button, lose, win} for the coming edge and the outputs expected after it
  task automatic sv(input logic [2:0] s, input logic [9:0] e);
    stimQ.push_back(s);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(rstv());
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset cyc %0d got %b exp %b", i, obs(), e);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    logic [9:0] e;
    int i = 0;
    sv(3'b111, st(0)); sv(3'b111, idle(3)); sv(3'b111, idle(3));
    sv(3'b011, ldv(1, 3)); sv(3'b111, plv(1, 3)); sv(3'b111, plv(1, 3));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL start step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_win_sequence();
    logic [9:0] e;
    int i = 0;
    for (int n = 2; n <= 4; n++) begin
      sv(3'b110, ldv(n, 3));
      sv(3'b111, plv(n, 3));
    end
    sv(3'b110, wov(3)); sv(3'b111, wov(3));
    sv(3'b011, st(3)); sv(3'b111, idle(3)); sv(3'b011, ldv(1, 3)); sv(3'b111, plv(1, 3));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL win_seq step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_lose_retry();
    logic [9:0] e;
    int i = 0;
    sv(3'b110, ldv(2, 3)); sv(3'b111, plv(2, 3));
    sv(3'b101, ldv(2, 2)); sv(3'b111, plv(2, 2));
    sv(3'b101, ldv(2, 1)); sv(3'b111, plv(2, 1));
    sv(3'b101, lov()); sv(3'b111, lov());
    sv(3'b011, st(0)); sv(3'b111, idle(3)); sv(3'b011, ldv(1, 3)); sv(3'b111, plv(1, 3));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL lose_retry step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] e;
    int i = 0;
    sv(3'b100, ldv(1, 2)); sv(3'b111, plv(1, 2)); sv(3'b111, plv(1, 2));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL simultaneous step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_held_start();
    logic [9:0] e;
    int i = 0;
    sv(3'b101, ldv(1, 1)); sv(3'b111, plv(1, 1)); sv(3'b101, lov()); sv(3'b011, st(0));
    for (int k = 0; k < 1000; k++) sv(3'b011, idle(3));
    sv(3'b111, idle(3)); sv(3'b011, ldv(1, 3)); sv(3'b111, plv(1, 3));
    sv(3'b110, ldv(2, 3)); sv(3'b111, plv(2, 3)); sv(3'b110, ldv(3, 3)); sv(3'b111, plv(3, 3));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL held_start step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] e;
    int i = 0;
    rst_n = 1'b0;
    sb.push_back(rstv());
    #1;
    e = sb.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL async_reset immediate got %b exp %b", obs(), e);
    end
    sb.push_back(rstv());
    tick();
    e = sb.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL async_reset held got %b exp %b", obs(), e);
    end
    rst_n = 1'b1;
    sv(3'b111, st(0)); sv(3'b111, idle(3)); sv(3'b011, ldv(1, 3)); sv(3'b111, plv(1, 3));
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL async_reset restart step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    int i = 0;
`ifdef SC_STATEMACHINELEVELS_TIMEOUT_EN
    int lv = 3;
    for (int k = 1; k <= 40; k++) begin
      if (k % 17 == 16) begin
        lv--;
        sv(3'b111, ldv(1, lv));
      end else sv(3'b111, plv(1, lv));
    end
`else
    for (int k = 1; k <= 40; k++) sv(3'b111, plv(1, 3));
`endif
    while (stimQ.size() > 0) begin
      {btn, loseIn, winIn} = stimQ.pop_front();
      tick();
      e = sb.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL timeout step %0d got %b exp %b", i, obs(), e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win_sequence();
    test_lose_retry();
    test_simultaneous();
    test_held_start();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
